// File: rtl/reg_bank_rw.sv
// Addressed bank of DEPTH x WIDTH registers with load/increment on one port and a
// registered, validated read-out port; q returns pre-edge contents (read-before-write).
module reg_bank_rw #(
  parameter int              WIDTH   = 8,
  parameter int              DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  localparam int             AW      = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             re,
  input  logic             inc,
  input  logic [AW-1:0]    re_addr,
  input  logic             we,
  input  logic [AW-1:0]    we_addr,
  output logic [WIDTH-1:0] q,
  output logic             q_vld,
  output logic             zero
);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [WIDTH-1:0] cur_val;
  logic [WIDTH-1:0] rd_val;
  logic [WIDTH-1:0] wr_next;
  logic [DEPTH-1:0] hit;
  logic [WIDTH-1:0] q_reg;
  logic             q_vld_reg;
  logic             zero_reg;

  // Address decode by scan: an out-of-range address matches nothing, so a
  // read yields 0 and a load/increment touches no register.
  always_comb begin
    cur_val = '0;
    rd_val  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (re_addr == AW'(i)) cur_val = mem_reg[i];
      if (we_addr == AW'(i)) rd_val  = mem_reg[i];
    end
    wr_next = !re ? d : cur_val + WIDTH'(1);
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_reg
      assign hit[gi] = (re_addr == AW'(gi)) && (!re || !inc);

      always_ff @(posedge clk) begin
        if (rst) begin
          mem_reg[gi] <= RST_VAL;
        end else if (hit[gi]) begin
          mem_reg[gi] <= wr_next;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg     <= '0;
      q_vld_reg <= 1'b0;
      zero_reg  <= (RST_VAL == '0);
    end else begin
      q_reg     <= !we ? rd_val : '0;
      q_vld_reg <= !we;
      if (|hit) zero_reg <= (wr_next == '0);
    end
  end

  assign q     = q_reg;
  assign q_vld = q_vld_reg;
  assign zero  = zero_reg;

endmodule

// File: tb/tb_reg_bank_rw.sv
// Scoreboard bench for reg_bank_rw: driver predicts each edge from an array model,
// monitor pops and compares q/q_vld/zero one edge later.
module tb_reg_bank_rw;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] d;
  logic       re, inc, we;
  logic [1:0] re_addr, we_addr;
  logic [7:0] q;
  logic       q_vld, zero;

  typedef struct {
    logic [7:0] q;
    logic       vld;
    logic       zero;
    int         tag;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] model_mem [4];
  logic       model_zero;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         tag = 0;

  always #5 clk = ~clk;

  reg_bank_rw #(.WIDTH(8), .DEPTH(4), .RST_VAL(8'h00)) dut (
    .clk(clk), .rst(rst), .d(d), .re(re), .inc(inc), .re_addr(re_addr),
    .we(we), .we_addr(we_addr), .q(q), .q_vld(q_vld), .zero(zero)
  );

  // One clock of stimulus; the expectation for the following edge is pushed
  // before that edge happens.
  task automatic cyc(input logic r, input logic [7:0] dd, input logic rr,
                     input logic ii, input logic [1:0] ra, input logic ww,
                     input logic [1:0] wa);
    exp_t e;
    @(negedge clk);
    rst = r; d = dd; re = rr; inc = ii; re_addr = ra; we = ww; we_addr = wa;
    e.tag = tag;
    if (r) begin
      for (int k = 0; k < 4; k++) model_mem[k] = 8'h00;
      model_zero = 1'b1;
      e.q = 8'h00; e.vld = 1'b0;
    end else begin
      e.vld = !ww;
      e.q   = !ww ? model_mem[wa] : 8'h00;
      if (!rr) begin
        model_mem[ra] = dd;
        model_zero    = (dd == 8'h00);
      end else if (!ii) begin
        model_mem[ra] = 8'((int'(model_mem[ra]) + 1) % 256);
        model_zero    = (model_mem[ra] == 8'h00);
      end
    end
    e.zero = model_zero;
    sb.push_back(e);
  endtask

  task automatic idle();
    cyc(1'b0, 8'h00, 1'b1, 1'b1, 2'd0, 1'b1, 2'd0);
  endtask

  task automatic rd(input logic [1:0] a);
    cyc(1'b0, 8'h00, 1'b1, 1'b1, 2'd0, 1'b0, a);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_cmp++;
        if (q !== e.q) begin
          n_bad++;
          $display("FAIL q tag=%0d t=%0t: got %h expected %h", e.tag, $time, q, e.q);
        end
        n_cmp++;
        if (q_vld !== e.vld) begin
          n_bad++;
          $display("FAIL q_vld tag=%0d t=%0t: got %b expected %b", e.tag, $time, q_vld, e.vld);
        end
        n_cmp++;
        if (zero !== e.zero) begin
          n_bad++;
          $display("FAIL zero tag=%0d t=%0t: got %b expected %b", e.tag, $time, zero, e.zero);
        end
        $display("tag=%0d q=%h q_vld=%b zero=%b", e.tag, q, q_vld, zero);
      end
    end
  end

  initial begin
    rst = 1'b1; d = 8'h00; re = 1'b1; inc = 1'b1; we = 1'b1;
    re_addr = 2'd0; we_addr = 2'd0;
    for (int k = 0; k < 4; k++) model_mem[k] = 8'h00;
    model_zero = 1'b1;

    // 1: reset with a load pending, then read every address
    tag = 1;
    cyc(1'b1, 8'hFF, 1'b0, 1'b1, 2'd0, 1'b1, 2'd0);
    cyc(1'b1, 8'hFF, 1'b0, 1'b1, 2'd0, 1'b1, 2'd0);
    for (int a = 0; a < 4; a++) rd(2'(a));

    // 2: load then write out, then release
    tag = 2;
    cyc(1'b0, 8'h5A, 1'b0, 1'b1, 2'd2, 1'b1, 2'd0);
    rd(2'd2);
    idle();

    // 3: same-address load and write: old value out
    tag = 3;
    cyc(1'b0, 8'h01, 1'b0, 1'b1, 2'd1, 1'b1, 2'd0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 2'd1, 1'b0, 2'd1);
    rd(2'd1);

    // 4: increment wrap and load-over-increment priority
    tag = 4;
    cyc(1'b0, 8'hFE, 1'b0, 1'b1, 2'd3, 1'b1, 2'd0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 2'd3, 1'b1, 2'd0);
    rd(2'd3);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 2'd3, 1'b1, 2'd0);
    rd(2'd3);
    cyc(1'b0, 8'h10, 1'b0, 1'b0, 2'd3, 1'b1, 2'd0);
    rd(2'd3);

    // 5: load discarded by simultaneous reset
    tag = 5;
    cyc(1'b0, 8'h33, 1'b0, 1'b1, 2'd0, 1'b1, 2'd0);
    cyc(1'b1, 8'hAA, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0);
    rd(2'd0);

    // 6: independent ports
    tag = 6;
    cyc(1'b0, 8'h22, 1'b0, 1'b1, 2'd2, 1'b1, 2'd0);
    cyc(1'b0, 8'h11, 1'b0, 1'b1, 2'd0, 1'b0, 2'd2);
    rd(2'd0);

    // 7: randomized traffic
    tag = 7;
    for (int n = 0; n < 400; n++) begin
      cyc(($urandom_range(0, 49) == 0), 8'($urandom),
          ($urandom_range(0, 2) != 0), ($urandom_range(0, 1) != 0),
          2'($urandom), ($urandom_range(0, 2) == 0), 2'($urandom));
    end
    idle();

    for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
